// File: rtl/bram_delay_pkg.sv
// Shared types and constants for the BRAM-backed circular delay line.
//   state_t  : controller states (IDLE -> CLEAR -> PRIME -> RUN)
//   MIN_LEN  : shortest legal delay; below this, read and write would hit one address
//   max_len  : longest legal delay for a given ring address width
package bram_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int MIN_LEN = 2;

    function automatic int max_len(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/bram_ring_ptr.sv
// Wrap-at-limit ring pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force pointer to 0 (has priority over advance)
//   advance    : step to ptr_nxt
//   limit      : ring length; pointer runs 0..limit-1
//   ptr        : current pointer
//   ptr_nxt    : pointer value after the next advance (wraps to 0)
//   last       : ptr is at limit-1
module bram_ring_ptr #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ADDR_WIDTH:0]   limit,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic [ADDR_WIDTH-1:0] ptr_nxt,
    output logic                  last
);

    assign last    = ({1'b0, ptr} == (limit - 1'b1));
    assign ptr_nxt = last ? '0 : ptr + 1'b1;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/bram_delay_line_ctrl.sv
// Controller that runs one true-dual-port BRAM (read on A, write on B) as a
// programmable-length circular delay line. Each accepted input sample is written
// at the write pointer while the word stored there LEN samples ago, prefetched
// on the previous fire, is presented on the output.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, stop, cfg_len       : control; cfg_len legal range 2..2**ADDR_WIDTH
//   cfg_err, busy              : status
//   in_valid/in_ready/in_data  : input stream
//   out_valid/out_ready/out_data : delayed output stream
//   ram_en_a/ram_addr_a/ram_dout_a : BRAM port A (read, unregistered output)
//   ram_we_b/ram_addr_b/ram_din_b  : BRAM port B (write)
module bram_delay_line_ctrl
    import bram_delay_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    output logic                  cfg_err,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_en_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b
);

    localparam int                LEN_W   = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0]  LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(max_len(ADDR_WIDTH));

    state_t                  state, state_nxt;
    logic [LEN_W-1:0]        len_q;
    logic                    cfg_ok;
    logic                    fire;
    logic [ADDR_WIDTH-1:0]   clr_ptr, wp, wp_nxt;
    logic                    clr_last;
    logic [ADDR_WIDTH-1:0]   clr_nxt_unused;
    logic                    wp_last_unused;

    assign cfg_ok   = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
    assign busy     = (state != IDLE);
    // stop withdraws ready in its own cycle so no sample is taken while abandoning.
    assign in_ready = (state == RUN) && !stop && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;

    bram_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .advance (state == CLEAR),
        .limit   (len_q),
        .ptr     (clr_ptr),
        .ptr_nxt (clr_nxt_unused),
        .last    (clr_last)
    );

    bram_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != RUN),
        .advance (fire),
        .limit   (len_q),
        .ptr     (wp),
        .ptr_nxt (wp_nxt),
        .last    (wp_last_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that left one
    // unassigned would infer a latch.
    always_comb begin
        state_nxt  = state;
        ram_en_a   = 1'b0;
        ram_addr_a = '0;
        ram_we_b   = 1'b0;
        ram_addr_b = '0;
        ram_din_b  = '0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = CLEAR;
            end
            CLEAR: begin
                ram_we_b   = 1'b1;
                ram_addr_b = clr_ptr;
                if (clr_last) state_nxt = PRIME;
            end
            PRIME: begin
                // Prefetch slot 0 so the first RUN fire already sees its old word.
                ram_en_a  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (fire) begin
                    // Write slot wp, prefetch slot wp_nxt; len_q >= 2 keeps them distinct.
                    ram_we_b   = 1'b1;
                    ram_addr_b = wp;
                    ram_din_b  = in_data;
                    ram_en_a   = 1'b1;
                    ram_addr_a = wp_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            cfg_err <= 1'b0;
        end else if (state == IDLE && start && !stop) begin
            if (cfg_ok) begin
                len_q   <= cfg_len;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Output holding register: a fire loads the prefetched word (the BRAM keeps
    // it latched while port A is disabled); a consume without a fire empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= ram_dout_a;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_delay_line_ctrl.sv
module tb_bram_delay_line_ctrl;

    localparam int AW = 9;
    localparam int DW = 36;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop;
    logic [AW:0]   cfg_len;
    logic          cfg_err, busy;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          ram_en_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_dout_a, ram_din_b;

    always #5 clk = ~clk;

    bram_delay_line_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_en_a(ram_en_a), .ram_addr_a(ram_addr_a), .ram_dout_a(ram_dout_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b)
    );

    // BRAM model: TDP, read-before-write, no output register, data held while EN=0.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en_a) ram_dout_a <= mem[ram_addr_a];
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard and reference history for the current run.
    logic [DW-1:0] sb[$];
    logic [DW-1:0] hist[$];
    int            cur_len = 4;
    int            n_out = 0;
    int            collisions = 0;
    int            idle_writes = 0;
    logic          fire_prev = 1'b0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            fire_prev = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (ram_en_a && ram_we_b && ram_addr_a == ram_addr_b) collisions++;
            if (!busy && ram_we_b) idle_writes++;
            if (fire_prev) check("latency_valid", out_valid, 1'b1);
            if (hold_pend) check("hold_data", out_data, hold_val);
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 1'b1, 1'b0);
                else check("out_data", out_data, sb.pop_front());
                n_out++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_data;
            fire_prev = in_valid && in_ready;
            if (fire_prev) begin
                hist.push_back(in_data);
                if (hist.size() > cur_len) sb.push_back(hist.pop_front());
                else sb.push_back('0);
            end
        end
    end

    task automatic do_start(input int len);
        @(posedge clk); #1;
        cfg_len = (AW + 1)'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cur_len = len;
        hist.delete();
    endtask

    task automatic do_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic send_seq(input int n, input logic [DW-1:0] base, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 2000) begin
                w++;
                if (i > 0) stalls++;
                @(negedge clk);
            end
            if (w >= 2000) begin
                check("in_ready_timeout", 1'b0, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        int w;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (out_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        @(negedge clk);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    int stalls;
    int n_out0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'({$urandom, $urandom});
        ram_dout_a = '0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_we_b", ram_we_b, 1'b0);
        check("rst_en_a", ram_en_a, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);

        // len=4, samples 1..8, sink always ready: full throughput.
        do_start(4);
        check("start4_busy", busy, 1'b1);
        send_seq(8, 36'd1, stalls);
        check("len4_stalls", stalls, 0);
        do_stop();
        drain();

        // len=4 with a 3-cycle sink stall mid-stream.
        n_out0 = n_out;
        do_start(4);
        fork
            send_seq(12, 36'h100, stalls);
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        do_stop();
        drain();
        check("stall_out_count", n_out - n_out0, 12);

        // Minimum length.
        do_start(2);
        send_seq(10, 36'h200, stalls);
        do_stop();
        drain();

        // Maximum length with wrap.
        n_out0 = n_out;
        do_start(512);
        send_seq(1100, 36'h1000, stalls);
        do_stop();
        drain();
        check("len512_out_count", n_out - n_out0, 1100);

        // Illegal lengths, then a legal one.
        do_start(1);
        check("len1_err", cfg_err, 1'b1);
        check("len1_busy", busy, 1'b0);
        do_start(513);
        check("len513_err", cfg_err, 1'b1);
        check("len513_busy", busy, 1'b0);
        do_start(0);
        check("len0_err", cfg_err, 1'b1);
        do_start(3);
        check("len3_err_clr", cfg_err, 1'b0);
        check("len3_busy", busy, 1'b1);
        send_seq(6, 36'h500, stalls);
        do_stop();
        drain();

        // Simultaneous start and stop in IDLE: stop wins.
        @(posedge clk); #1;
        cfg_len = 5; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 1'b0);

        // stop with an output pending: word survives until consumed.
        do_start(4);
        out_ready = 1'b0;
        send_seq(1, 36'h600, stalls);
        stop = 1'b1;
        @(negedge clk);
        check("stop_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop_busy", busy, 1'b0);
        check("stop_pending_valid", out_valid, 1'b1);
        drain();

        // Reset in the middle of CLEAR, then restart with len=8 over a dirty RAM.
        do_start(1);
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'({$urandom, $urandom});
        do_start(16);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_we_b", ram_we_b, 1'b0);
        check("midrst_cfg_err", cfg_err, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_start(8);
        send_seq(12, 36'h700, stalls);
        do_stop();
        drain();

        check("no_collision", collisions, 0);
        check("no_idle_writes", idle_writes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
